decode_pipe_ctrl: RTL and testbench
===================================

// Module: decode_pipe_ctrl
// PURPOSE
//  Registered ID->EX decode stage. Decodes opcode into the control bundle and registers it with a valid bit.
//  Adds a parametrised load-use interlock, branch flush and downstream hold; fetch/PC logic stalls on in_ready=0.
// PARAMETERS
//  OP_BITS          6  opcode width; class = opcode[OP_BITS-1:OP_BITS-2]
//  REG_BITS         5  register-address width
//  LOAD_USE_STALLS  1  bubbles inserted on a load-use RAW; 0 disables the interlock
// PORTS
//  clk          in   1              rising-edge clock; the only clock
//  reset        in   1              synchronous, active-high
//  in_valid     in   1              opcode/rs/rt/rd hold a real instruction
//  in_ready     out  1              instruction accepted this cycle (comb.)
//  opcode       in   OP_BITS        instruction opcode
//  rs,rt,rd     in   REG_BITS each  source/destination fields
//  flush        in   1              taken branch resolved in EX; kill the stage
//  hold         in   1              downstream stall; freeze the output register
//  out_valid    out  1              output bundle is a real instruction
//  reg_dst, alu_src, mem_to_reg, reg_write, address_src  out 1  registered control bits
//  alu_op       out  ALU_OP_BITS    registered
//  mem_op       out  MEM_OP_BITS    registered
//  jop          out  JUMP_BITS      registered
//  dst_reg      out  REG_BITS       registered write target: rd if reg_dst else rt
// BEHAVIOUR
//  Reset: all outputs 0 / *_NOP; out_valid=0; FSM=RUN; counter=0. Latency: 1 cycle from accept to outputs.
//  Decode (comb.; every signal assigned on every path, no latches):
//  - 000000: full NOP.
//  - 00xxxx reg ALU: reg_dst=1, alu_src=0; reads rs,rt.
//  - 01xxxx imm ALU: reg_dst=0, alu_src=1; reads rs.
//  - CMP/TEST/CMPI/TESTI: reg_write=0. All other ALU ops: reg_write=1.
//  - 10xxxx memory: alu_src=1, mem_to_reg=1.
//    LW:  ADD, address_src=0, read,  write.    Reads rs.
//    LA:  NOP, address_src=1, read,  write.    No reads.
//    SW:  ADD, address_src=0, write, no write. Reads rs,rt.
//    SA:  NOP, address_src=1, write, no write. Reads rt.
//  - 11xxxx jump: jop per jump table, reg_write=0. JR reads rs.
//  - Undefined opcode: full NOP, out_valid=1.
//  Priority per cycle: reset > flush > hold > interlock > issue.
//  - flush: next out_valid=0, bundle=NOP, FSM->RUN, counter=0, last-load tracker cleared; in_ready=0.
//  - hold (no flush): output register and FSM frozen; in_ready=0.
//  - RUN, in_valid=1:
//    - Hazard if LOAD_USE_STALLS>0 and the last issued instruction is a valid LW/LA with dst_reg!=0
//      and dst_reg equal to a register this opcode reads.
//    - Hazard: in_ready=0, bubble issued (out_valid=0), ->STALL, counter=LOAD_USE_STALLS-1,
//      tracker cleared.
//    - No hazard: in_ready=1, bundle registered, out_valid=1; tracker loads {is_load, dst_reg}.
//  - STALL: in_ready=0, bubble each cycle; counter decrements; at 0 ->RUN.
//    Instruction then issues with no re-check.
//  - in_valid=0 in RUN: bubble, tracker cleared. Register 0 never causes a hazard.
// STRUCTURE
//  - Shared package/defines.vh: OP_CODE_* , ALU_OP_*, MEM_OP_*, JMP_OP_*, *_BITS, and state encodings
//    ST_RUN/ST_STALL.
//  - Sub-module ctrl_decode: pure combinational opcode -> {bundle, reads_rs, reads_rt}.
//    Registering, FSM and tracker live in the top.
// TESTING
//  1. reset=1 for 2 cycles, then ADD r3=r1+r2 with in_valid -> next cycle out_valid=1, alu_op=ADD,
//     reg_write=1, dst_reg=3.
//  2. LW r4 then ADD r5=r4+r1 back-to-back, LOAD_USE_STALLS=1 -> one bubble, ADD issued 2 cycles after LW.
//     With =2: two bubbles. With =0: none.
//  3. CMP r1,r2 and CMPI r1,#5 -> reg_write=0, alu_op=CMP; LW r0 followed by a use of r0 -> no stall.
//  4. flush during STALL -> next out_valid=0, FSM=RUN; the following instruction is accepted same cycle.
//  5. hold=1 for 3 cycles with SW bundle -> outputs unchanged, in_ready=0; flush+hold together -> flush wins.
//  6. Undefined opcode and 000000 -> all controls NOP; reset asserted mid-STALL -> reset values next cycle.

Source files
------------

// File: rtl/decode_pipe_ctrl_pkg.sv
// Shared encodings for the ID->EX decode stage: opcode classes/functions,
// control-field encodings, FSM state codes and the registered control bundle.
package decode_pipe_ctrl_pkg;

  localparam int unsigned ALU_OP_BITS = 3;
  localparam int unsigned MEM_OP_BITS = 2;
  localparam int unsigned JUMP_BITS   = 3;

  localparam logic [1:0] CLS_REG = 2'b00;
  localparam logic [1:0] CLS_IMM = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_JMP = 2'b11;

  // Function field (low opcode bits); ALU functions are shared by reg and imm classes
  localparam logic [3:0] FN_NOP  = 4'd0;
  localparam logic [3:0] FN_ADD  = 4'd1;
  localparam logic [3:0] FN_SUB  = 4'd2;
  localparam logic [3:0] FN_AND  = 4'd3;
  localparam logic [3:0] FN_OR   = 4'd4;
  localparam logic [3:0] FN_XOR  = 4'd5;
  localparam logic [3:0] FN_CMP  = 4'd6;
  localparam logic [3:0] FN_TEST = 4'd7;
  localparam logic [3:0] FN_LW   = 4'd0;
  localparam logic [3:0] FN_LA   = 4'd1;
  localparam logic [3:0] FN_SW   = 4'd2;
  localparam logic [3:0] FN_SA   = 4'd3;
  localparam logic [3:0] FN_J    = 4'd0;
  localparam logic [3:0] FN_JZ   = 4'd1;
  localparam logic [3:0] FN_JNZ  = 4'd2;
  localparam logic [3:0] FN_JR   = 4'd3;

  localparam logic [5:0] OP_CODE_NOP   = {CLS_REG, FN_NOP};
  localparam logic [5:0] OP_CODE_ADD   = {CLS_REG, FN_ADD};
  localparam logic [5:0] OP_CODE_SUB   = {CLS_REG, FN_SUB};
  localparam logic [5:0] OP_CODE_AND   = {CLS_REG, FN_AND};
  localparam logic [5:0] OP_CODE_OR    = {CLS_REG, FN_OR};
  localparam logic [5:0] OP_CODE_XOR   = {CLS_REG, FN_XOR};
  localparam logic [5:0] OP_CODE_CMP   = {CLS_REG, FN_CMP};
  localparam logic [5:0] OP_CODE_TEST  = {CLS_REG, FN_TEST};
  localparam logic [5:0] OP_CODE_ADDI  = {CLS_IMM, FN_ADD};
  localparam logic [5:0] OP_CODE_CMPI  = {CLS_IMM, FN_CMP};
  localparam logic [5:0] OP_CODE_TESTI = {CLS_IMM, FN_TEST};
  localparam logic [5:0] OP_CODE_LW    = {CLS_MEM, FN_LW};
  localparam logic [5:0] OP_CODE_LA    = {CLS_MEM, FN_LA};
  localparam logic [5:0] OP_CODE_SW    = {CLS_MEM, FN_SW};
  localparam logic [5:0] OP_CODE_SA    = {CLS_MEM, FN_SA};
  localparam logic [5:0] OP_CODE_J     = {CLS_JMP, FN_J};
  localparam logic [5:0] OP_CODE_JZ    = {CLS_JMP, FN_JZ};
  localparam logic [5:0] OP_CODE_JNZ   = {CLS_JMP, FN_JNZ};
  localparam logic [5:0] OP_CODE_JR    = {CLS_JMP, FN_JR};

  localparam logic [ALU_OP_BITS-1:0] ALU_OP_NOP  = 3'd0;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_ADD  = 3'd1;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_SUB  = 3'd2;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_AND  = 3'd3;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_OR   = 3'd4;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_XOR  = 3'd5;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_CMP  = 3'd6;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_TEST = 3'd7;

  localparam logic [MEM_OP_BITS-1:0] MEM_OP_NOP   = 2'd0;
  localparam logic [MEM_OP_BITS-1:0] MEM_OP_READ  = 2'd1;
  localparam logic [MEM_OP_BITS-1:0] MEM_OP_WRITE = 2'd2;

  localparam logic [JUMP_BITS-1:0] JMP_OP_NOP = 3'd0;
  localparam logic [JUMP_BITS-1:0] JMP_OP_J   = 3'd1;
  localparam logic [JUMP_BITS-1:0] JMP_OP_JZ  = 3'd2;
  localparam logic [JUMP_BITS-1:0] JMP_OP_JNZ = 3'd3;
  localparam logic [JUMP_BITS-1:0] JMP_OP_JR  = 3'd4;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  typedef struct packed {
    logic                   reg_dst;
    logic                   alu_src;
    logic                   mem_to_reg;
    logic                   reg_write;
    logic                   address_src;
    logic [ALU_OP_BITS-1:0] alu_op;
    logic [MEM_OP_BITS-1:0] mem_op;
    logic [JUMP_BITS-1:0]   jop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/decode_pipe_ctrl_if.sv
// Issue-side handshake plus registered control bundle of the decode stage.
interface decode_pipe_ctrl_if #(
  parameter int unsigned OP_BITS  = 6,
  parameter int unsigned REG_BITS = 5
);
  import decode_pipe_ctrl_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [OP_BITS-1:0]     opcode;
  logic [REG_BITS-1:0]    rs;
  logic [REG_BITS-1:0]    rt;
  logic [REG_BITS-1:0]    rd;
  logic                   flush;
  logic                   hold;
  logic                   out_valid;
  logic                   reg_dst;
  logic                   alu_src;
  logic                   mem_to_reg;
  logic                   reg_write;
  logic                   address_src;
  logic [ALU_OP_BITS-1:0] alu_op;
  logic [MEM_OP_BITS-1:0] mem_op;
  logic [JUMP_BITS-1:0]   jop;
  logic [REG_BITS-1:0]    dst_reg;

  modport master (
    output in_valid, opcode, rs, rt, rd, flush, hold,
    input  in_ready, out_valid, reg_dst, alu_src, mem_to_reg, reg_write,
           address_src, alu_op, mem_op, jop, dst_reg
  );

  modport slave (
    input  in_valid, opcode, rs, rt, rd, flush, hold,
    output in_ready, out_valid, reg_dst, alu_src, mem_to_reg, reg_write,
           address_src, alu_op, mem_op, jop, dst_reg
  );
endinterface

// File: rtl/decode_pipe_ctrl_ctrl_decode.sv
// Pure combinational opcode decoder: control bundle plus which source
// registers the instruction reads (for the load-use interlock).
module ctrl_decode
  import decode_pipe_ctrl_pkg::*;
#(
  parameter int unsigned OP_BITS = 6
) (
  input  logic [OP_BITS-1:0] opcode,
  output ctrl_t              ctrl,
  output logic               reads_rs,
  output logic               reads_rt
);

  logic [1:0]             cls;
  logic [31:0]            fn;
  logic [ALU_OP_BITS-1:0] alu;

  always_comb begin
    cls      = opcode[OP_BITS-1 -: 2];
    fn       = 32'(opcode[OP_BITS-3:0]);
    ctrl     = CTRL_NOP;
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    alu      = ALU_OP_NOP;

    case (cls)
      CLS_REG, CLS_IMM: begin
        case (fn)
          32'(FN_ADD):  alu = ALU_OP_ADD;
          32'(FN_SUB):  alu = ALU_OP_SUB;
          32'(FN_AND):  alu = ALU_OP_AND;
          32'(FN_OR):   alu = ALU_OP_OR;
          32'(FN_XOR):  alu = ALU_OP_XOR;
          32'(FN_CMP):  alu = ALU_OP_CMP;
          32'(FN_TEST): alu = ALU_OP_TEST;
          default:      alu = ALU_OP_NOP;
        endcase
        // NOP function and undefined functions both leave the full NOP bundle
        if (alu != ALU_OP_NOP) begin
          ctrl.alu_op    = alu;
          ctrl.reg_dst   = (cls == CLS_REG);
          ctrl.alu_src   = (cls == CLS_IMM);
          ctrl.reg_write = !(alu == ALU_OP_CMP || alu == ALU_OP_TEST);
          reads_rs       = 1'b1;
          reads_rt       = (cls == CLS_REG);
        end
      end
      CLS_MEM: begin
        case (fn)
          32'(FN_LW): begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.alu_op     = ALU_OP_ADD;
            ctrl.mem_op     = MEM_OP_READ;
            ctrl.reg_write  = 1'b1;
            reads_rs        = 1'b1;
          end
          32'(FN_LA): begin
            ctrl.alu_src     = 1'b1;
            ctrl.mem_to_reg  = 1'b1;
            ctrl.address_src = 1'b1;
            ctrl.mem_op      = MEM_OP_READ;
            ctrl.reg_write   = 1'b1;
          end
          32'(FN_SW): begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.alu_op     = ALU_OP_ADD;
            ctrl.mem_op     = MEM_OP_WRITE;
            reads_rs        = 1'b1;
            reads_rt        = 1'b1;
          end
          32'(FN_SA): begin
            ctrl.alu_src     = 1'b1;
            ctrl.mem_to_reg  = 1'b1;
            ctrl.address_src = 1'b1;
            ctrl.mem_op      = MEM_OP_WRITE;
            reads_rt         = 1'b1;
          end
          default: ;
        endcase
      end
      default: begin
        case (fn)
          32'(FN_J):   ctrl.jop = JMP_OP_J;
          32'(FN_JZ):  ctrl.jop = JMP_OP_JZ;
          32'(FN_JNZ): ctrl.jop = JMP_OP_JNZ;
          32'(FN_JR): begin
            ctrl.jop = JMP_OP_JR;
            reads_rs = 1'b1;
          end
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/decode_pipe_ctrl.sv
// Registered ID->EX decode stage with load-use interlock, branch flush and
// downstream hold. Fetch stalls whenever in_ready is low.
module decode_pipe_ctrl
  import decode_pipe_ctrl_pkg::*;
#(
  parameter int unsigned OP_BITS         = 6,
  parameter int unsigned REG_BITS        = 5,
  parameter int unsigned LOAD_USE_STALLS = 1
) (
  input logic               clk,
  input logic               reset,
  decode_pipe_ctrl_if.slave bus
);

  localparam int unsigned CNT_BITS = (LOAD_USE_STALLS > 1) ? $clog2(LOAD_USE_STALLS) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD =
    CNT_BITS'((LOAD_USE_STALLS > 0) ? LOAD_USE_STALLS - 1 : 0);

  ctrl_t               dec_ctrl;
  logic                dec_rs;
  logic                dec_rt;
  logic [REG_BITS-1:0] dst_next;
  logic                hazard;

  logic [0:0]          state;
  logic [CNT_BITS-1:0] cnt;
  logic                trk_load;
  logic [REG_BITS-1:0] trk_reg;
  logic                out_valid_q;
  ctrl_t               ctrl_q;
  logic [REG_BITS-1:0] dst_q;

  ctrl_decode #(.OP_BITS(OP_BITS)) u_decode (
    .opcode   (bus.opcode),
    .ctrl     (dec_ctrl),
    .reads_rs (dec_rs),
    .reads_rt (dec_rt)
  );

  always_comb begin
    dst_next = dec_ctrl.reg_dst ? bus.rd : bus.rt;
    hazard   = (LOAD_USE_STALLS > 0) && trk_load && (trk_reg != '0) &&
               ((dec_rs && bus.rs == trk_reg) || (dec_rt && bus.rt == trk_reg));
    bus.in_ready = !bus.flush && !bus.hold && (state == ST_RUN) && bus.in_valid && !hazard;
  end

  // A single-bubble interlock never enters STALL: the hazard cycle is the bubble.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      state       <= ST_RUN;
      cnt         <= '0;
      trk_load    <= 1'b0;
      trk_reg     <= '0;
      out_valid_q <= 1'b0;
      ctrl_q      <= CTRL_NOP;
      dst_q       <= '0;
    end else if (!bus.hold) begin
      if (state == ST_STALL || !bus.in_valid || hazard) begin
        out_valid_q <= 1'b0;
        ctrl_q      <= CTRL_NOP;
        dst_q       <= '0;
        trk_load    <= 1'b0;
        trk_reg     <= '0;
        if (state == ST_STALL) begin
          cnt <= cnt - CNT_BITS'(1);
          if (cnt <= CNT_BITS'(1)) state <= ST_RUN;
        end else if (bus.in_valid) begin
          cnt   <= CNT_LOAD;
          state <= (CNT_LOAD == '0) ? ST_RUN : ST_STALL;
        end
      end else begin
        out_valid_q <= 1'b1;
        ctrl_q      <= dec_ctrl;
        dst_q       <= dst_next;
        trk_load    <= (dec_ctrl.mem_op == MEM_OP_READ);
        trk_reg     <= dst_next;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.reg_dst     = ctrl_q.reg_dst;
  assign bus.alu_src     = ctrl_q.alu_src;
  assign bus.mem_to_reg  = ctrl_q.mem_to_reg;
  assign bus.reg_write   = ctrl_q.reg_write;
  assign bus.address_src = ctrl_q.address_src;
  assign bus.alu_op      = ctrl_q.alu_op;
  assign bus.mem_op      = ctrl_q.mem_op;
  assign bus.jop         = ctrl_q.jop;
  assign bus.dst_reg     = dst_q;

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Directed bench: three decode stages (1, 2 and 0 load-use bubbles) share one
// input stream; full bundles are compared on the single-bubble instance.
module tb_decode_pipe_ctrl;
  import decode_pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [18:0] obs1;

  always #5 clk = ~clk;

  decode_pipe_ctrl_if #(.OP_BITS(6), .REG_BITS(5)) b1 ();
  decode_pipe_ctrl_if #(.OP_BITS(6), .REG_BITS(5)) b2 ();
  decode_pipe_ctrl_if #(.OP_BITS(6), .REG_BITS(5)) b0 ();

  decode_pipe_ctrl #(.OP_BITS(6), .REG_BITS(5), .LOAD_USE_STALLS(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1));
  decode_pipe_ctrl #(.OP_BITS(6), .REG_BITS(5), .LOAD_USE_STALLS(2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2));
  decode_pipe_ctrl #(.OP_BITS(6), .REG_BITS(5), .LOAD_USE_STALLS(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0));

  assign obs1 = {b1.out_valid, b1.reg_dst, b1.alu_src, b1.mem_to_reg, b1.reg_write,
                 b1.address_src, b1.alu_op, b1.mem_op, b1.jop, b1.dst_reg};

  function automatic logic [18:0] bundle(input logic v, input logic rdst, input logic asrc,
                                         input logic m2r, input logic rw, input logic adr,
                                         input logic [2:0] alu, input logic [1:0] mem,
                                         input logic [2:0] j, input logic [4:0] dst);
    return {v, rdst, asrc, m2r, rw, adr, alu, mem, j, dst};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic fl, input logic hd);
    b1.in_valid = v; b1.opcode = op; b1.rs = rs; b1.rt = rt; b1.rd = rd; b1.flush = fl; b1.hold = hd;
    b2.in_valid = v; b2.opcode = op; b2.rs = rs; b2.rt = rt; b2.rd = rd; b2.flush = fl; b2.hold = hd;
    b0.in_valid = v; b0.opcode = op; b0.rs = rs; b0.rt = rt; b0.rd = rd; b0.flush = fl; b0.hold = hd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    drive(1'b0, OP_CODE_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, OP_CODE_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    check("reset_bundle", 32'(obs1), 32'(0));
    check("reset_valid2", 32'(b2.out_valid), 32'(0));
    reset = 1'b0;

    // ADD r3 = r1 + r2
    drive(1'b1, OP_CODE_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    #1 check("add_ready", 32'(b1.in_ready), 32'(1));
    tick();
    check("add", 32'(obs1), 32'(bundle(1, 1, 0, 0, 1, 0, ALU_OP_ADD, MEM_OP_NOP, JMP_OP_NOP, 5'd3)));

    // Compares write no register
    drive(1'b1, OP_CODE_CMP, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0);
    tick();
    check("cmp", 32'(obs1), 32'(bundle(1, 1, 0, 0, 0, 0, ALU_OP_CMP, MEM_OP_NOP, JMP_OP_NOP, 5'd7)));
    drive(1'b1, OP_CODE_CMPI, 5'd1, 5'd6, 5'd0, 1'b0, 1'b0);
    tick();
    check("cmpi", 32'(obs1), 32'(bundle(1, 0, 1, 0, 0, 0, ALU_OP_CMP, MEM_OP_NOP, JMP_OP_NOP, 5'd6)));
    drive(1'b1, OP_CODE_SUB, 5'd2, 5'd3, 5'd9, 1'b0, 1'b0);
    tick();
    check("sub", 32'(obs1), 32'(bundle(1, 1, 0, 0, 1, 0, ALU_OP_SUB, MEM_OP_NOP, JMP_OP_NOP, 5'd9)));
    idle(1);
    check("idle_bubble", 32'(b1.out_valid), 32'(0));

    // LW r4 then ADD r5 = r4 + r1, presented for three cycles
    drive(1'b1, OP_CODE_LW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0);
    tick();
    check("lw", 32'(obs1), 32'(bundle(1, 0, 1, 1, 1, 0, ALU_OP_ADD, MEM_OP_READ, JMP_OP_NOP, 5'd4)));
    drive(1'b1, OP_CODE_ADD, 5'd4, 5'd1, 5'd5, 1'b0, 1'b0);
    #1;
    check("lu_rdy_b_n1", 32'(b1.in_ready), 32'(0));
    check("lu_rdy_b_n2", 32'(b2.in_ready), 32'(0));
    check("lu_rdy_b_n0", 32'(b0.in_ready), 32'(1));
    tick();
    check("lu_vld_b_n1", 32'(b1.out_valid), 32'(0));
    check("lu_vld_b_n2", 32'(b2.out_valid), 32'(0));
    check("lu_vld_b_n0", 32'(b0.out_valid), 32'(1));
    #1;
    check("lu_rdy_c_n1", 32'(b1.in_ready), 32'(1));
    check("lu_rdy_c_n2", 32'(b2.in_ready), 32'(0));
    tick();
    check("lu_add_n1", 32'(obs1), 32'(bundle(1, 1, 0, 0, 1, 0, ALU_OP_ADD, MEM_OP_NOP, JMP_OP_NOP, 5'd5)));
    check("lu_vld_c_n2", 32'(b2.out_valid), 32'(0));
    #1 check("lu_rdy_d_n2", 32'(b2.in_ready), 32'(1));
    tick();
    check("lu_vld_d_n2", 32'(b2.out_valid), 32'(1));
    check("lu_dst_d_n2", 32'(b2.dst_reg), 32'(5));
    idle(1);

    // Load into r0 never interlocks
    drive(1'b1, OP_CODE_LW, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    check("lw_r0", 32'(obs1), 32'(bundle(1, 0, 1, 1, 1, 0, ALU_OP_ADD, MEM_OP_READ, JMP_OP_NOP, 5'd0)));
    drive(1'b1, OP_CODE_ADD, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    #1 check("r0_no_stall", 32'(b1.in_ready), 32'(1));
    tick();
    check("r0_add", 32'(obs1), 32'(bundle(1, 1, 0, 0, 1, 0, ALU_OP_ADD, MEM_OP_NOP, JMP_OP_NOP, 5'd5)));

    // LA r6 followed by SA reading r6 through rt
    drive(1'b1, OP_CODE_LA, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0);
    tick();
    check("la", 32'(obs1), 32'(bundle(1, 0, 1, 1, 1, 1, ALU_OP_NOP, MEM_OP_READ, JMP_OP_NOP, 5'd6)));
    drive(1'b1, OP_CODE_SA, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0);
    #1 check("sa_stall", 32'(b1.in_ready), 32'(0));
    tick();
    check("sa_bubble", 32'(b1.out_valid), 32'(0));
    #1 check("sa_ready", 32'(b1.in_ready), 32'(1));
    tick();
    check("sa", 32'(obs1), 32'(bundle(1, 0, 1, 1, 0, 1, ALU_OP_NOP, MEM_OP_WRITE, JMP_OP_NOP, 5'd6)));
    idle(2);

    // Flush while the two-bubble instance sits in STALL
    drive(1'b1, OP_CODE_LW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, OP_CODE_ADD, 5'd4, 5'd1, 5'd5, 1'b0, 1'b0);
    tick();
    drive(1'b1, OP_CODE_ADD, 5'd4, 5'd1, 5'd5, 1'b1, 1'b0);
    #1 check("flush_rdy_n2", 32'(b2.in_ready), 32'(0));
    tick();
    check("flush_vld_n2", 32'(b2.out_valid), 32'(0));
    check("flush_bundle_n1", 32'(obs1), 32'(0));
    drive(1'b1, OP_CODE_ADD, 5'd4, 5'd1, 5'd5, 1'b0, 1'b0);
    #1 check("post_flush_rdy_n2", 32'(b2.in_ready), 32'(1));
    tick();
    check("post_flush_vld_n2", 32'(b2.out_valid), 32'(1));
    idle(1);

    // SW held for three cycles, then flush overrides hold
    drive(1'b1, OP_CODE_SW, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0);
    tick();
    check("sw", 32'(obs1), 32'(bundle(1, 0, 1, 1, 0, 0, ALU_OP_ADD, MEM_OP_WRITE, JMP_OP_NOP, 5'd3)));
    drive(1'b1, OP_CODE_ADD, 5'd1, 5'd1, 5'd9, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      #1 check("hold_rdy", 32'(b1.in_ready), 32'(0));
      tick();
      check("hold_sw", 32'(obs1), 32'(bundle(1, 0, 1, 1, 0, 0, ALU_OP_ADD, MEM_OP_WRITE, JMP_OP_NOP, 5'd3)));
    end
    drive(1'b1, OP_CODE_ADD, 5'd1, 5'd1, 5'd9, 1'b1, 1'b1);
    tick();
    check("flush_over_hold", 32'(obs1), 32'(0));

    // Undefined opcodes, 000000 and jumps
    drive(1'b1, 6'b001111, 5'd1, 5'd7, 5'd2, 1'b0, 1'b0);
    tick();
    check("undef_reg", 32'(obs1), 32'(bundle(1, 0, 0, 0, 0, 0, ALU_OP_NOP, MEM_OP_NOP, JMP_OP_NOP, 5'd7)));
    drive(1'b1, 6'b101010, 5'd1, 5'd8, 5'd2, 1'b0, 1'b0);
    tick();
    check("undef_mem", 32'(obs1), 32'(bundle(1, 0, 0, 0, 0, 0, ALU_OP_NOP, MEM_OP_NOP, JMP_OP_NOP, 5'd8)));
    drive(1'b1, OP_CODE_NOP, 5'd3, 5'd0, 5'd4, 1'b0, 1'b0);
    tick();
    check("nop", 32'(obs1), 32'(bundle(1, 0, 0, 0, 0, 0, ALU_OP_NOP, MEM_OP_NOP, JMP_OP_NOP, 5'd0)));
    drive(1'b1, OP_CODE_JR, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    check("jr", 32'(obs1), 32'(bundle(1, 0, 0, 0, 0, 0, ALU_OP_NOP, MEM_OP_NOP, JMP_OP_JR, 5'd0)));
    drive(1'b1, OP_CODE_JNZ, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    check("jnz", 32'(obs1), 32'(bundle(1, 0, 0, 0, 0, 0, ALU_OP_NOP, MEM_OP_NOP, JMP_OP_JNZ, 5'd0)));
    drive(1'b1, OP_CODE_XOR, 5'd1, 5'd2, 5'd10, 1'b0, 1'b0);
    tick();
    check("xor", 32'(obs1), 32'(bundle(1, 1, 0, 0, 1, 0, ALU_OP_XOR, MEM_OP_NOP, JMP_OP_NOP, 5'd10)));
    drive(1'b1, OP_CODE_TESTI, 5'd2, 5'd11, 5'd0, 1'b0, 1'b0);
    tick();
    check("testi", 32'(obs1), 32'(bundle(1, 0, 1, 0, 0, 0, ALU_OP_TEST, MEM_OP_NOP, JMP_OP_NOP, 5'd11)));
    idle(1);

    // Reset asserted while the two-bubble instance is in STALL
    drive(1'b1, OP_CODE_LW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, OP_CODE_ADD, 5'd4, 5'd1, 5'd5, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check("mid_reset_n1", 32'(obs1), 32'(0));
    check("mid_reset_n2", 32'(b2.out_valid), 32'(0));
    reset = 1'b0;
    #1 check("post_reset_rdy_n2", 32'(b2.in_ready), 32'(1));
    tick();
    check("post_reset_vld_n2", 32'(b2.out_valid), 32'(1));
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
